// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver with a show-ahead byte FIFO and sticky error flags.
// The clock line is filtered, frames are checked for odd parity and stop bit, and the clock is inhibited while the FIFO is full.
module ps2_rx_fifo #(
  parameter int DEPTH_LOG2     = 4,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 9000
) (
  input  logic                  main_clk,
  input  logic                  main_reset,
  input  logic                  ps2_clock_in,
  input  logic                  ps2_data_in,
  output logic                  ps2_clock_pulldown,
  output logic                  ps2_data_pulldown,
  input  logic                  rd_en,
  output logic [7:0]            rd_data,
  output logic                  rd_valid,
  output logic [DEPTH_LOG2:0]   fifo_count,
  input  logic                  clear_flags,
  output logic                  overflow_flag,
  output logic                  parity_err_flag,
  output logic                  framing_err_flag
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int FW    = $clog2(FILTER_LEN + 1);
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  logic clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic filt_q, filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic ps2_edge;

  state_t state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [9:0] shift_q, shift_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic push, set_pe, set_fe;

  logic [7:0] mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0] count_q, count_d;
  logic pop, full, push_ok, set_ovf;
  logic ovf_q, ovf_d, pe_q, pe_d, fe_q, fe_d;

  always_ff @(posedge main_clk) begin
    if (main_reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
    end else begin
      clk_s1_q   <= ps2_clock_in;
      clk_s2_q   <= clk_s1_q;
      dat_s1_q   <= ps2_data_in;
      dat_s2_q   <= dat_s1_q;
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
    end
  end

  // Level flips only after FILTER_LEN consecutive disagreeing samples.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (clk_s2_q != filt_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) filt_d = clk_s2_q;
      else filt_cnt_d = filt_cnt_q + 1'b1;
    end
  end

  assign ps2_edge = filt_q & ~filt_d;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    to_cnt_d  = to_cnt_q;
    push      = 1'b0;
    set_pe    = 1'b0;
    set_fe    = 1'b0;
    case (state_q)
      IDLE: begin
        to_cnt_d = '0;
        if (ps2_edge && !dat_s2_q) begin
          state_d   = RECV;
          bit_cnt_d = '0;
        end
      end
      RECV: begin
        if (ps2_edge) begin
          shift_d  = {dat_s2_q, shift_q[9:1]};
          to_cnt_d = '0;
          if (bit_cnt_q == 4'd9) state_d = DONE;
          else bit_cnt_d = bit_cnt_q + 4'd1;
        end else if (to_cnt_q == TW'(TIMEOUT_CYCLES)) begin
          set_fe    = 1'b1;
          state_d   = IDLE;
          bit_cnt_d = '0;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
        // shift_q = {stop, parity, data[7:0]}
        if (!shift_q[9]) set_fe = 1'b1;
        else if (!(^shift_q[8:0])) set_pe = 1'b1;
        else push = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign full    = (count_q == (DEPTH_LOG2 + 1)'(DEPTH));
  assign rd_valid = (count_q != '0);
  assign pop     = rd_en && rd_valid;
  assign push_ok = push && (!full || pop);
  assign set_ovf = push && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    ovf_d = (ovf_q & ~clear_flags) | set_ovf;
    pe_d  = (pe_q & ~clear_flags) | set_pe;
    fe_d  = (fe_q & ~clear_flags) | set_fe;
  end

  always_ff @(posedge main_clk) begin
    if (main_reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      to_cnt_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      pe_q      <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      to_cnt_q  <= to_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      pe_q      <= pe_d;
      fe_q      <= fe_d;
    end
  end

  // Storage needs no reset: rd_data is masked while the FIFO is empty.
  always_ff @(posedge main_clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= shift_q[7:0];
  end

  assign rd_data            = rd_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign fifo_count         = count_q;
  assign ps2_clock_pulldown = (state_q == IDLE) && full;
  assign ps2_data_pulldown  = 1'b0;
  assign overflow_flag      = ovf_q;
  assign parity_err_flag    = pe_q;
  assign framing_err_flag   = fe_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: a PS/2 device model sends frames with a 30-cycle bit period
// (1 MHz main_clk, so 30 us); a vector table plus hand sequences cover full/overflow, timeout, glitch and reset.
`timescale 1ns/1ps
module tb_ps2_rx_fifo;

  logic       main_clk = 1'b0;
  logic       main_reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       rd_en = 1'b0;
  logic       clear_flags = 1'b0;
  logic       ps2_clock_pulldown, ps2_data_pulldown, rd_valid;
  logic [7:0] rd_data;
  logic [4:0] fifo_count;
  logic       overflow_flag, parity_err_flag, framing_err_flag;

  int n_chk = 0;
  int n_pass = 0;

  always #500 main_clk = ~main_clk;

  ps2_rx_fifo dut (
    .main_clk           (main_clk),
    .main_reset         (main_reset),
    .ps2_clock_in       (ps2_clk),
    .ps2_data_in        (ps2_dat),
    .ps2_clock_pulldown (ps2_clock_pulldown),
    .ps2_data_pulldown  (ps2_data_pulldown),
    .rd_en              (rd_en),
    .rd_data            (rd_data),
    .rd_valid           (rd_valid),
    .fifo_count         (fifo_count),
    .clear_flags        (clear_flags),
    .overflow_flag      (overflow_flag),
    .parity_err_flag    (parity_err_flag),
    .framing_err_flag   (framing_err_flag)
  );

  typedef struct {
    logic       clr;
    logic [7:0] d;
    logic       par_flip;
    logic       stop;
    int         exp_cnt;
    logic [7:0] exp_rd;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge main_clk);
  endtask

  task automatic do_reset();
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    main_reset = 1'b1;
    cycles(3);
    main_reset = 1'b0;
    cycles(2);
  endtask

  // Sends the first nbits of {stop, odd parity ^ par_flip, data, start}.
  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_val, input int nbits);
    logic [10:0] fr;
    fr = {stop_val, (~^d) ^ par_flip, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = fr[i];
      cycles(8);
      ps2_clk = 1'b0;
      cycles(15);
      ps2_clk = 1'b1;
      cycles(7);
    end
    ps2_dat = 1'b1;
    cycles(40);
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    cycles(1);
    rd_en = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1;
    cycles(1);
    clear_flags = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b0, 8'h1C, 1'b0, 1'b1, 1, 8'h1C, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'h1C, 1'b1, 1'b1, 1, 8'h1C, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 8'h55, 1'b0, 1'b1, 2, 8'h1C, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 3, 8'h1C, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 8'hFF, 1'b0, 1'b0, 3, 8'h1C, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 8'h80, 1'b0, 1'b1, 4, 8'h1C, 1'b0, 1'b0};

    do_reset();
    check("reset count", fifo_count, 0);
    check("reset rd_valid", rd_valid, 0);
    check("reset rd_data", rd_data, 8'h00);
    check("reset flags", {overflow_flag, parity_err_flag, framing_err_flag}, 3'b000);
    check("reset clk_pulldown", ps2_clock_pulldown, 0);
    check("data_pulldown", ps2_data_pulldown, 0);

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].clr) pulse_clear();
      send_frame(vecs[v].d, vecs[v].par_flip, vecs[v].stop, 11);
      check($sformatf("vec%0d count", v), fifo_count, vecs[v].exp_cnt);
      check($sformatf("vec%0d rd_data", v), rd_data, vecs[v].exp_rd);
      check($sformatf("vec%0d rd_valid", v), rd_valid, 1);
      check($sformatf("vec%0d parity_err", v), parity_err_flag, vecs[v].exp_pe);
      check($sformatf("vec%0d framing_err", v), framing_err_flag, vecs[v].exp_fe);
      check($sformatf("vec%0d overflow", v), overflow_flag, 0);
    end

    begin
      logic [7:0] exp_seq[4];
      exp_seq = '{8'h1C, 8'h55, 8'h00, 8'h80};
      for (int k = 0; k < 4; k++) begin
        check($sformatf("drain%0d rd_data", k), rd_data, exp_seq[k]);
        pop_one();
      end
    end
    check("drained rd_valid", rd_valid, 0);
    pop_one();
    check("empty pop count", fifo_count, 0);
    check("empty pop rd_data", rd_data, 8'h00);

    // Fill to depth, then force one more frame through the inhibit.
    do_reset();
    for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b0, 1'b1, 11);
    check("full count", fifo_count, 16);
    check("full pulldown", ps2_clock_pulldown, 1);
    check("full head", rd_data, 8'h00);
    check("full no overflow", overflow_flag, 0);
    send_frame(8'h10, 1'b0, 1'b1, 11);
    check("overflow flag", overflow_flag, 1);
    check("overflow count", fifo_count, 16);
    check("overflow head", rd_data, 8'h00);
    pop_one();
    check("pop head next", rd_data, 8'h01);
    check("pop pulldown released", ps2_clock_pulldown, 0);
    check("pop count", fifo_count, 15);
    for (int j = 1; j < 16; j++) begin
      check($sformatf("full drain%0d", j), rd_data, j);
      pop_one();
    end
    check("full drain empty", rd_valid, 0);
    check("overflow sticky", overflow_flag, 1);
    pulse_clear();
    check("overflow cleared", overflow_flag, 0);

    // Truncated frame followed by a long idle must time out.
    do_reset();
    send_frame(8'h1F, 1'b0, 1'b1, 6);
    check("pre-timeout framing", framing_err_flag, 0);
    cycles(9100);
    check("timeout framing", framing_err_flag, 1);
    check("timeout count", fifo_count, 0);
    send_frame(8'hF0, 1'b0, 1'b1, 11);
    check("post-timeout count", fifo_count, 1);
    check("post-timeout rd_data", rd_data, 8'hF0);
    check("post-timeout parity", parity_err_flag, 0);

    // Short clock glitch with data low must not start a frame.
    do_reset();
    ps2_dat = 1'b0;
    cycles(5);
    ps2_clk = 1'b0;
    cycles(3);
    ps2_clk = 1'b1;
    cycles(50);
    ps2_dat = 1'b1;
    cycles(5);
    check("glitch count", fifo_count, 0);
    check("glitch flags", {overflow_flag, parity_err_flag, framing_err_flag}, 3'b000);
    send_frame(8'h3C, 1'b0, 1'b1, 11);
    check("after glitch count", fifo_count, 1);
    check("after glitch rd_data", rd_data, 8'h3C);
    check("after glitch flags", {overflow_flag, parity_err_flag, framing_err_flag}, 3'b000);

    // Reset in the middle of a frame.
    do_reset();
    send_frame(8'h12, 1'b0, 1'b1, 5);
    do_reset();
    check("midreset count", fifo_count, 0);
    send_frame(8'hAA, 1'b0, 1'b1, 11);
    check("midreset AA count", fifo_count, 1);
    check("midreset AA rd_data", rd_data, 8'hAA);
    check("midreset flags", {overflow_flag, parity_err_flag, framing_err_flag}, 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
